// File: rtl/encoder_decoder_neuron_acc.sv
// Neuron accumulator: sums N_INPUTS signed products, adds a bias, applies ReLU,
// rescales by an arithmetic right shift and clips to an unsigned activation.
// Valid/ready on both sides; one bubble cycle per neuron while the result drains.
module encoder_decoder_neuron_acc #(
  parameter int PROD_W   = 23,
  parameter int ACC_W    = 32,
  parameter int N_INPUTS = 16,
  parameter int BIAS_W   = 16,
  parameter int SHIFT    = 8,
  parameter int OUT_W    = 13
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic signed [PROD_W-1:0]         prod_data,
  input  logic                             prod_valid,
  output logic                             prod_ready,
  input  logic signed [BIAS_W-1:0]         bias,
  output logic        [OUT_W-1:0]          act_data,
  output logic                             act_valid,
  input  logic                             act_ready,
  output logic                             sat_pulse,
  output logic [$clog2(N_INPUTS+1)-1:0]    cnt
);

  localparam int                      CNT_W   = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0]        LAST    = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << OUT_W) - 1);

  // The accumulator must hold N_INPUTS full-scale products plus the bias without wrapping.
  if (ACC_W < PROD_W + $clog2(N_INPUTS) + 1) begin : g_acc_w_chk
    $error("ACC_W too narrow for PROD_W and N_INPUTS");
  end
  if (N_INPUTS < 1) begin : g_n_chk
    $error("N_INPUTS must be at least 1");
  end

  typedef enum logic {S_ACC, S_OUT} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic        [OUT_W-1:0]   data_q, data_d;
  logic                      vld_q, vld_d;
  logic                      sat_q, sat_d;
  logic signed [ACC_W-1:0]   sum;
  logic        [OUT_W:0]     res;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_bias(input logic signed [BIAS_W-1:0] b);
    return {{(ACC_W-BIAS_W){b[BIAS_W-1]}}, b};
  endfunction

  // Returns {upper_clip, activation}; negative values clip to zero without flagging saturation.
  function automatic logic [OUT_W:0] relu_sat(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] sh;
    sh = s >>> SHIFT;
    if (sh < 0)            return '0;
    else if (sh > OUT_MAX) return {1'b1, {OUT_W{1'b1}}};
    else                   return {1'b0, sh[OUT_W-1:0]};
  endfunction

  // Next-state logic: accumulate in S_ACC, finalize on the last product, hold the result in S_OUT.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    vld_d   = vld_q;
    sat_d   = 1'b0;
    sum     = acc_q + sext_prod(prod_data) + sext_bias(bias);
    res     = relu_sat(sum);
    case (state_q)
      S_ACC: begin
        if (prod_valid) begin
          if (cnt_q == LAST) begin
            data_d  = res[OUT_W-1:0];
            sat_d   = res[OUT_W];
            vld_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_OUT;
          end else begin
            acc_d = acc_q + sext_prod(prod_data);
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_OUT: begin
        if (act_ready) begin
          vld_d   = 1'b0;
          state_d = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  // State and datapath registers; reset discards any partial sum or pending result.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      sat_q   <= sat_d;
    end
  end

  assign prod_ready = (state_q == S_ACC);
  assign act_data   = data_q;
  assign act_valid  = vld_q;
  assign sat_pulse  = sat_q;
  assign cnt        = cnt_q;

endmodule

// File: tb/tb_encoder_decoder_neuron_acc.sv
// Bench for encoder_decoder_neuron_acc (N_INPUTS=4): directed cases plus random
// traffic, compared against a neuron-level reference model.
module tb_encoder_decoder_neuron_acc;

  localparam int N     = 4;
  localparam int OUT_W = 13;

  logic               ap_clk;
  logic               ap_rst_n;
  logic signed [22:0] prod_data;
  logic               prod_valid;
  logic               prod_ready;
  logic signed [15:0] bias;
  logic [OUT_W-1:0]   act_data;
  logic               act_valid;
  logic               act_ready;
  logic               sat_pulse;
  logic [2:0]         cnt;

  encoder_decoder_neuron_acc #(.N_INPUTS(N)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .prod_data (prod_data),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .bias      (bias),
    .act_data  (act_data),
    .act_valid (act_valid),
    .act_ready (act_ready),
    .sat_pulse (sat_pulse),
    .cnt       (cnt)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct { int data; bit sat; } exp_t;
  exp_t   exp_q[$];
  longint m_sum;
  int     m_n;
  bit     m_vld;
  bit     m_first;
  int     last_data;
  int     sat_hi_cnt;
  int     rdy_mode;   // 0: always ready, 1: random, 2: hold low for 3 valid cycles

  // Activation from a full neuron sum: floor(sum/256), ReLU, clip to 8191
  function automatic exp_t neuron_out(input longint s);
    exp_t e;
    longint q;
    q = (s >= 0) ? (s / 256) : -((-s + 255) / 256);
    e.sat = 1'b0;
    if (q < 0)         e.data = 0;
    else if (q > 8191) begin e.data = 8191; e.sat = 1'b1; end
    else               e.data = int'(q);
    return e;
  endfunction

  // Monitor: checks every cycle away from the edge, then advances the model
  initial begin
    m_sum = 0; m_n = 0; m_vld = 0; m_first = 0; last_data = -1; sat_hi_cnt = 0;
    forever begin
      @(negedge ap_clk);
      #3;
      if (!ap_rst_n) begin
        m_sum = 0; m_n = 0; m_vld = 0; m_first = 0;
        exp_q.delete();
      end else begin
        if (sat_pulse) sat_hi_cnt++;
        chk("cnt", cnt, m_n);
        chk("act_valid", act_valid, m_vld);
        chk("prod_ready", prod_ready, !m_vld);
        if (m_vld && exp_q.size() > 0) begin
          chk("act_data", act_data, exp_q[0].data);
          chk("sat_pulse", sat_pulse, m_first && exp_q[0].sat);
        end else begin
          chk("sat_pulse_idle", sat_pulse, 0);
        end
        m_first = 0;
        if (m_vld && act_ready) begin
          last_data = act_data;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_vld = 0;
        end
        if (prod_valid && prod_ready) begin
          m_sum += longint'(prod_data);
          m_n++;
          if (m_n == N) begin
            exp_q.push_back(neuron_out(m_sum + longint'(bias)));
            m_sum = 0; m_n = 0; m_vld = 1; m_first = 1;
          end
        end
      end
    end
  end

  // Downstream ready driver
  initial begin
    int hold;
    hold = 0;
    act_ready = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (act_valid) hold++; else hold = 0;
      case (rdy_mode)
        0:       act_ready = 1'b1;
        1:       act_ready = ($urandom_range(0, 1) == 1);
        default: act_ready = (hold >= 4);
      endcase
    end
  end

  // Present one product (called at a falling edge) and hold it until accepted
  task automatic push_prod(input int d, input int b);
    bit took;
    int guard;
    took = 0; guard = 0;
    prod_data  = d[22:0];
    bias       = b[15:0];
    prod_valid = 1'b1;
    while (!took && guard < 200) begin
      #1;
      took = prod_ready;
      @(negedge ap_clk);
      guard++;
    end
    prod_valid = 1'b0;
    if (!took) chk("prod_accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || act_valid) && g < 300) begin
      @(negedge ap_clk);
      g++;
    end
    if (g >= 300) chk("drain_timeout", 0, 1);
    @(negedge ap_clk);
  endtask

  initial begin
    int s0;
    int r;
    ap_rst_n = 1'b0; prod_data = '0; prod_valid = 1'b0; bias = '0; rdy_mode = 0;
    repeat (3) @(negedge ap_clk);
    chk("rst_cnt", cnt, 0);
    chk("rst_act_valid", act_valid, 0);
    chk("rst_act_data", act_data, 0);
    chk("rst_sat_pulse", sat_pulse, 0);
    #1 ap_rst_n = 1'b1;
    #1 chk("rst_prod_ready", prod_ready, 1);
    @(negedge ap_clk);

    // Basic neuron: 256+512-256+1024 = 1536 >> 8 = 6
    push_prod(256, 0); push_prod(512, 0); push_prod(-256, 0); push_prod(1024, 0);
    drain();
    chk("tp_basic", last_data, 6);

    // Truncation toward -inf
    push_prod(511, 0); push_prod(0, 0); push_prod(0, 0); push_prod(0, 0);
    drain();
    chk("tp_trunc", last_data, 1);

    // ReLU clip is not saturation
    s0 = sat_hi_cnt;
    push_prod(-1000, 100); push_prod(0, 100); push_prod(0, 100); push_prod(0, 100);
    drain();
    chk("tp_relu", last_data, 0);
    chk("tp_relu_nosat", sat_hi_cnt - s0, 0);

    // Upper saturation, pulse lasts exactly one cycle
    s0 = sat_hi_cnt;
    rdy_mode = 2;
    repeat (4) push_prod(4194303, 0);
    drain();
    chk("tp_sat", last_data, 8191);
    chk("tp_sat_once", sat_hi_cnt - s0, 1);

    // Backpressure: next product held high while the result waits
    rdy_mode = 2;
    repeat (4) push_prod(256, 0);
    push_prod(768, 0);
    push_prod(0, 0); push_prod(0, 0); push_prod(0, 0);
    drain();
    chk("tp_backpressure", last_data, 3);
    rdy_mode = 0;

    // Bias sampled with the last product only
    push_prod(256, 50); push_prod(256, 50); push_prod(256, 50); push_prod(256, 512);
    drain();
    chk("tp_bias_sample", last_data, 6);

    // Reset in the middle of a neuron
    push_prod(1000, 0); push_prod(2000, 0);
    #1 ap_rst_n = 1'b0;
    #1 chk("rst_mid_cnt", cnt, 0);
    chk("rst_mid_act_valid", act_valid, 0);
    #2 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    repeat (4) push_prod(256, 0);
    drain();
    chk("tp_after_reset", last_data, 4);

    // Random traffic with random downstream readiness
    rdy_mode = 1;
    for (int k = 0; k < 30 * N; k++) begin
      if ($urandom_range(0, 3) == 0) @(negedge ap_clk);
      if ($urandom_range(0, 1) == 1) r = int'($urandom);
      else                           r = int'($urandom_range(0, 4000)) - 2000;
      push_prod(r, int'($urandom));
    end
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/encoder_decoder_neuron_acc.md
Name: encoder_decoder_neuron_acc

Overview:
Downstream consumer of the layer's weight×activation multiplier. It accepts a stream of signed 23-bit products, accumulates N_INPUTS of them per neuron, adds a bias, applies ReLU, and rescales by an arithmetic right shift. It saturates the result to an unsigned 13-bit activation that feeds the next layer's multiplier operand. Valid/ready handshakes are used on both sides.

Parameters:
PROD_W, 23, product width (signed, matches the multiplier output)
ACC_W, 32, accumulator width (signed); must be >= PROD_W + clog2(N_INPUTS) + 1, checked by a simulation assertion
N_INPUTS, 16, products summed per neuron; must be >= 1
BIAS_W, 16, bias width (signed, product scale)
SHIFT, 8, arithmetic right shift applied after the bias add
OUT_W, 13, output activation width (unsigned)

Ports:
ap_clk  in  1  clock; all state updates on the rising edge
ap_rst_n  in  1  asynchronous active-low reset
prod_data  in  PROD_W  signed product
prod_valid  in  1  product valid
prod_ready  out  1  block can accept a product
bias  in  BIAS_W  signed bias; sampled on the cycle the last product of a neuron is accepted
act_data  out  OUT_W  unsigned activation result
act_valid  out  1  result valid
act_ready  in  1  downstream accepts the result
sat_pulse  out  1  one-cycle pulse, high with the first act_valid cycle when upper clipping occurred
cnt  out  clog2(N_INPUTS+1)  products accepted for the current neuron (debug/status)

Behaviour:
- Reset (async assert, sync release): state=ACC, acc=0, cnt=0, act_data=0, act_valid=0, sat_pulse=0. prod_ready=1 after reset.
- Accept condition: prod_valid & prod_ready.
- State ACC:
  - prod_ready=1.
  - On accept with cnt < N_INPUTS-1: acc <= acc + sext(prod_data); cnt++.
  - On accept with cnt == N_INPUTS-1:
    - sum = acc + sext(prod_data) + sext(bias), computed at ACC_W.
    - sh = sum >>> SHIFT (arithmetic shift, truncation toward -inf, no rounding).
    - act_data <= 0 if sh < 0; 2^OUT_W-1 if sh > 2^OUT_W-1; otherwise sh[OUT_W-1:0].
    - sat_pulse <= 1 only if the upper clip applies. ReLU clipping to 0 is not saturation.
    - act_valid <= 1; acc <= 0; cnt <= 0; state -> OUT.
  - Latency: act_valid is high on the cycle after the last product is accepted.
- State OUT:
  - prod_ready=0; acc and cnt hold.
  - act_data and act_valid stay stable until act_ready=1.
  - sat_pulse returns to 0 after one cycle even if the result is still held.
  - On act_valid & act_ready: act_valid <= 0; state -> ACC. prod_ready rises the next cycle, so one bubble cycle per neuron.
- N_INPUTS=1: every accepted product completes a neuron.
- prod_valid with prod_ready=0: the product is not consumed; the upstream holds its data.
- act_ready high while act_valid=0: ignored.
- Reset asserted mid-neuron: partial sum and cnt are discarded immediately. The next N_INPUTS accepted products form a fresh neuron.
- Reset asserted in OUT: the pending result is lost and act_valid drops asynchronously.
- Accumulator: assuming the parameter assertion holds, it cannot overflow, so no wrap handling is required.

Test Plan:
- N_INPUTS=4, SHIFT=8, bias=0; products 256, 512, -256, 1024 back-to-back; act_ready=1 -> act_data=6 one cycle after the 4th accept; sat_pulse=0; cnt sequence 0,1,2,3,0.
- Truncation: products 511, 0, 0, 0; bias=0 -> act_data=1. ReLU: products -1000, 0, 0, 0; bias=100 -> act_data=0, sat_pulse=0.
- Saturation: four products of 4194303 -> sum 16777212, >>8 = 65535 -> act_data=8191; sat_pulse high for exactly one cycle.
- Backpressure: act_ready held low 3 cycles after act_valid -> act_data stable; prod_ready=0; a prod_valid held high is not consumed and is accepted the cycle after prod_ready returns.
- Bias sampling: products 256×4; bias changes 50 -> 512 on the 4th-accept cycle -> act_data=(1024+512)>>8=6.
- Reset mid-neuron: accept 2 products (cnt=2), pulse ap_rst_n low mid-cycle -> cnt=0, act_valid=0 immediately; then products 256×4 with bias=0 -> act_data=4.
